// File: rtl/uart_rx_fsm_p.sv
// UART receiver control FSM: sequences start/data/parity/stop phases and emits frame result pulses.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_fsm_p #(
  parameter int DATA_W = 8,
  parameter int BCNT_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              STOP2,
  input  logic              bit_done,
  input  logic              strt_glitch,
  input  logic              par_err,
  input  logic              stp_err,
  output logic              dat_sampl_en,
  output logic              enable,
  output logic              str_chk_en,
  output logic              deser_en,
  output logic              par_chk_en,
  output logic              stp_chk_en,
  output logic [BCNT_W-1:0] bit_idx,
  output logic              data_valid,
  output logic              frame_err,
  output logic              par_err_o,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    VALID  = 3'd5
`ifdef UART_RX_BREAK_DET_EN
    , BREAK = 3'd6
`endif
  } state_t;

  localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [BCNT_W-1:0] bit_idx_nxt;
  logic              stop_cnt, stop_cnt_nxt;
  logic              par_en_q, par_en_nxt;
  logic              stop2_q, stop2_nxt;
  logic              dv_nxt, fe_nxt, pe_nxt;
`ifdef UART_RX_BREAK_DET_EN
  logic              zeros_q, zeros_nxt;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      par_err_o  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      zeros_q    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      bit_idx    <= bit_idx_nxt;
      stop_cnt   <= stop_cnt_nxt;
      par_en_q   <= par_en_nxt;
      stop2_q    <= stop2_nxt;
      data_valid <= dv_nxt;
      frame_err  <= fe_nxt;
      par_err_o  <= pe_nxt;
`ifdef UART_RX_BREAK_DET_EN
      zeros_q    <= zeros_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_idx_nxt  = bit_idx;
    stop_cnt_nxt = stop_cnt;
    par_en_nxt   = par_en_q;
    stop2_nxt    = stop2_q;
    dv_nxt       = 1'b0;
    fe_nxt       = 1'b0;
    pe_nxt       = 1'b0;
    dat_sampl_en = 1'b0;
    enable       = 1'b0;
    str_chk_en   = 1'b0;
    deser_en     = 1'b0;
    par_chk_en   = 1'b0;
    stp_chk_en   = 1'b0;
    busy         = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    zeros_nxt    = zeros_q;
`endif
    case (state)
      IDLE: begin
        stop_cnt_nxt = 1'b0;
        if (!RX_IN) begin
          state_nxt  = START;
          par_en_nxt = PAR_EN;
          stop2_nxt  = STOP2;
        end
      end
      START: begin
        busy         = 1'b1;
        str_chk_en   = 1'b1;
        dat_sampl_en = 1'b1;
        enable       = 1'b1;
        if (bit_done) begin
          if (strt_glitch) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
`ifdef UART_RX_BREAK_DET_EN
            zeros_nxt   = 1'b1;
`endif
          end
        end
      end
      DATA: begin
        busy         = 1'b1;
        deser_en     = 1'b1;
        dat_sampl_en = 1'b1;
        enable       = 1'b1;
        if (bit_done) begin
`ifdef UART_RX_BREAK_DET_EN
          zeros_nxt = zeros_q & ~RX_IN;
`endif
          // bit_idx parks on the last index so it never wraps past DATA_W-1
          if (bit_idx == LAST_IDX) begin
            state_nxt    = par_en_q ? PARITY : STOP;
            stop_cnt_nxt = 1'b0;
          end else begin
            bit_idx_nxt = bit_idx + BCNT_W'(1);
          end
        end
      end
      PARITY: begin
        busy         = 1'b1;
        par_chk_en   = 1'b1;
        dat_sampl_en = 1'b1;
        enable       = 1'b1;
        if (bit_done) begin
`ifdef UART_RX_BREAK_DET_EN
          zeros_nxt = zeros_q & ~RX_IN;
`endif
          if (par_err) begin
            state_nxt = IDLE;
            pe_nxt    = 1'b1;
          end else begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        busy         = 1'b1;
        stp_chk_en   = 1'b1;
        dat_sampl_en = 1'b1;
        enable       = 1'b1;
        if (bit_done) begin
          if (stp_err) begin
            fe_nxt    = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
            state_nxt = zeros_q ? BREAK : IDLE;
`else
            state_nxt = IDLE;
`endif
          end else if (!stop2_q || stop_cnt) begin
            state_nxt = VALID;
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end
      end
      VALID: begin
        busy   = 1'b1;
        dv_nxt = 1'b1;
        // a start bit landing in this cycle chains straight into the next frame
        if (!RX_IN) begin
          state_nxt  = START;
          par_en_nxt = PAR_EN;
          stop2_nxt  = STOP2;
        end else begin
          state_nxt = IDLE;
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      BREAK: begin
        busy = 1'b1;
        if (RX_IN) state_nxt = IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fsm_p.sv
// Directed bench for uart_rx_fsm_p: drives bit periods by hand and scoreboards result pulses.
// Break-detection checks compile in only when UART_RX_BREAK_DET_EN is defined.
module tb_uart_rx_fsm_p;

  localparam int PH_START  = 1;
  localparam int PH_DATA   = 2;
  localparam int PH_PARITY = 3;
  localparam int PH_STOP   = 4;
  localparam int K_VALID   = 1;
  localparam int K_FRAME   = 2;
  localparam int K_PARITY  = 3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst8, rst7;
  logic RX_IN, PAR_EN, STOP2, bit_done, strt_glitch, par_err, stp_err;

  logic d8_dat, d8_en, d8_str, d8_deser, d8_par, d8_stp, d8_dv, d8_fe, d8_pe, d8_busy;
  logic [3:0] d8_bidx;
  logic d7_dat, d7_en, d7_str, d7_deser, d7_par, d7_stp, d7_dv, d7_fe, d7_pe, d7_busy;
  logic [3:0] d7_bidx;

  uart_rx_fsm_p #(.DATA_W(8), .BCNT_W(4)) dut8 (
    .CLK(CLK), .RST(rst8), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .STOP2(STOP2),
    .bit_done(bit_done), .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .dat_sampl_en(d8_dat), .enable(d8_en), .str_chk_en(d8_str), .deser_en(d8_deser),
    .par_chk_en(d8_par), .stp_chk_en(d8_stp), .bit_idx(d8_bidx),
    .data_valid(d8_dv), .frame_err(d8_fe), .par_err_o(d8_pe), .busy(d8_busy)
  );

  uart_rx_fsm_p #(.DATA_W(7), .BCNT_W(4)) dut7 (
    .CLK(CLK), .RST(rst7), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .STOP2(STOP2),
    .bit_done(bit_done), .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .dat_sampl_en(d7_dat), .enable(d7_en), .str_chk_en(d7_str), .deser_en(d7_deser),
    .par_chk_en(d7_par), .stp_chk_en(d7_stp), .bit_idx(d7_bidx),
    .data_valid(d7_dv), .frame_err(d7_fe), .par_err_o(d7_pe), .busy(d7_busy)
  );

  int sel = 8;
  logic m_dat, m_en, m_str, m_deser, m_par, m_stp, m_dv, m_fe, m_pe, m_busy;
  logic [3:0] m_bidx;
  assign m_dat   = (sel == 7) ? d7_dat   : d8_dat;
  assign m_en    = (sel == 7) ? d7_en    : d8_en;
  assign m_str   = (sel == 7) ? d7_str   : d8_str;
  assign m_deser = (sel == 7) ? d7_deser : d8_deser;
  assign m_par   = (sel == 7) ? d7_par   : d8_par;
  assign m_stp   = (sel == 7) ? d7_stp   : d8_stp;
  assign m_dv    = (sel == 7) ? d7_dv    : d8_dv;
  assign m_fe    = (sel == 7) ? d7_fe    : d8_fe;
  assign m_pe    = (sel == 7) ? d7_pe    : d8_pe;
  assign m_busy  = (sel == 7) ? d7_busy  : d8_busy;
  assign m_bidx  = (sel == 7) ? d7_bidx  : d8_bidx;

  int nVectors = 0;
  int nMiss    = 0;
  int sb[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiss++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s miscompare", tag);
    end
  endtask

  task automatic scoreCheck(input int id, input logic [2:0] pulses);
    int kind;
    case (pulses)
      3'b001:  kind = K_VALID;
      3'b010:  kind = K_FRAME;
      3'b100:  kind = K_PARITY;
      default: kind = 15;
    endcase
    if (sb.size() == 0) checkOutput("sb_unexpected", id * 16 + kind, 0);
    else                checkOutput("sb_pulse", id * 16 + kind, sb.pop_front());
  endtask

  // Any result pulse from either DUT must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (d8_dv | d8_fe | d8_pe) scoreCheck(8, {d8_pe, d8_fe, d8_dv});
    if (d7_dv | d7_fe | d7_pe) scoreCheck(7, {d7_pe, d7_fe, d7_dv});
  end

  task automatic checkPhase(input int phase, input int idx);
    logic [3:0] exp_en;
    case (phase)
      PH_START:  exp_en = 4'b1000;
      PH_DATA:   exp_en = 4'b0100;
      PH_PARITY: exp_en = 4'b0010;
      default:   exp_en = 4'b0001;
    endcase
    checkOutput("busy", m_busy, 1);
    checkOutput("phase_en", {m_str, m_deser, m_par, m_stp}, exp_en);
    if (phase == PH_START || phase == PH_DATA) checkOutput("samp_en", {m_dat, m_en}, 2'b11);
    if (phase == PH_DATA) checkOutput("bit_idx", m_bidx, idx);
  endtask

  task automatic applyStimulus(input logic v, input int phase, input int idx,
                               input logic perr, input logic serr, input logic c0busy);
    for (int c = 0; c < 4; c++) begin
      RX_IN       = v;
      bit_done    = (c == 3);
      strt_glitch = 1'b0;
      par_err     = (c == 3) & perr;
      stp_err     = (c == 3) & serr;
      @(negedge CLK);
      if (phase == PH_START && c == 0) checkOutput("start_c0_busy", m_busy, c0busy);
      else checkPhase(phase, idx);
      @(posedge CLK); #1;
    end
    bit_done = 1'b0; par_err = 1'b0; stp_err = 1'b0;
  endtask

  task automatic sendFrame(input logic [8:0] data, input int nbits, input logic pen, input logic s2,
                           input logic perr, input int serrAt, input logic stopVal,
                           input logic b2bIn, input logic b2bOut, input logic flipCfg);
    logic pbit;
    pbit   = 1'b0;
    PAR_EN = pen;
    STOP2  = s2;
    if (pen && perr)      sb.push_back(sel * 16 + K_PARITY);
    else if (serrAt != 0) sb.push_back(sel * 16 + K_FRAME);
    else                  sb.push_back(sel * 16 + K_VALID);
    applyStimulus(1'b0, PH_START, 0, 1'b0, 1'b0, b2bIn);
    if (flipCfg) begin PAR_EN = ~pen; STOP2 = ~s2; end
    for (int i = 0; i < nbits; i++) begin
      pbit ^= data[i];
      applyStimulus(data[i], PH_DATA, i, 1'b0, 1'b0, 1'b0);
    end
    if (pen) begin
      applyStimulus(pbit, PH_PARITY, 0, perr, 1'b0, 1'b0);
      if (perr) begin
        RX_IN = 1'b1;
        @(negedge CLK);
        checkOutput("perr_pulse", {m_pe, m_fe, m_dv}, 3'b100);
        checkOutput("perr_idle", m_busy, 0);
        @(posedge CLK); #1;
        return;
      end
    end
    for (int k = 1; k <= (s2 ? 2 : 1); k++) begin
      applyStimulus(stopVal, PH_STOP, 0, 1'b0, (serrAt == k), 1'b0);
      if (serrAt == k) begin
        if (stopVal) begin
          RX_IN = 1'b1;
          @(negedge CLK);
          checkOutput("ferr_pulse", {m_pe, m_fe, m_dv}, 3'b010);
          checkOutput("ferr_idle", m_busy, 0);
          @(posedge CLK); #1;
        end
        return;
      end
    end
    PAR_EN = pen; STOP2 = s2;
    if (b2bOut) return;
    RX_IN = 1'b1;
    @(negedge CLK);
    checkOutput("valid_busy", m_busy, 1);
    checkOutput("valid_early", m_dv, 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    checkOutput("dv_pulse", {m_pe, m_fe, m_dv}, 3'b001);
    checkOutput("dv_idle", m_busy, 0);
    @(posedge CLK); #1;
  endtask

  task automatic idleCycles(input int n);
    RX_IN = 1'b1;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  initial begin
    rst8 = 1'b0; rst7 = 1'b0;
    RX_IN = 1'b1; PAR_EN = 1'b0; STOP2 = 1'b0;
    bit_done = 1'b0; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    #1 rst8 = 1'b1; rst7 = 1'b1;

    // reset state
    @(negedge CLK);
    checkOutput("rst_outputs", {m_busy, m_dv, m_fe, m_pe}, 4'b0000);
    checkOutput("rst_bit_idx", m_bidx, 0);
    @(posedge CLK); #1 rst8 = 1'b0;
    idleCycles(2);

    // bit_done and checker flags in IDLE are ignored
    bit_done = 1'b1; stp_err = 1'b1; par_err = 1'b1; strt_glitch = 1'b1;
    @(negedge CLK);
    checkOutput("idle_bitdone_busy", m_busy, 0);
    @(posedge CLK); #1;
    bit_done = 1'b0; stp_err = 1'b0; par_err = 1'b0; strt_glitch = 1'b0;
    @(negedge CLK);
    checkOutput("idle_bitdone_pulses", {m_pe, m_fe, m_dv}, 3'b000);
    @(posedge CLK); #1;

    // 8N1 frame 0xA5
    sendFrame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycles(2);

    // one-sample low glitch on the start bit
    for (int c = 0; c < 4; c++) begin
      RX_IN = (c == 0) ? 1'b0 : 1'b1;
      bit_done = (c == 3); strt_glitch = (c == 3);
      @(negedge CLK);
      checkOutput("glitch_busy", m_busy, (c == 0) ? 0 : 1);
      @(posedge CLK); #1;
    end
    bit_done = 1'b0; strt_glitch = 1'b0;
    @(negedge CLK);
    checkOutput("glitch_idle", m_busy, 0);
    @(posedge CLK); #1;
    idleCycles(1);

    // 8N2 with PAR_EN/STOP2 flipped mid-frame, then 8N2 with an error on the 2nd stop bit
    sendFrame(9'h05A, 8, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    idleCycles(2);
    sendFrame(9'h05A, 8, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycles(2);

    // 8E1 good frame
    sendFrame(9'h081, 8, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycles(2);

    // back-to-back 0x3C frames
    sendFrame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    sendFrame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    idleCycles(2);

    // reset in the middle of data bit 4
    PAR_EN = 1'b0; STOP2 = 1'b0;
    applyStimulus(1'b0, PH_START, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, PH_DATA, i, 1'b0, 1'b0, 1'b0);
    RX_IN = 1'b0;
    @(negedge CLK);
    checkPhase(PH_DATA, 4);
    #2 rst8 = 1'b1;
    #1;
    checkOutput("rst_mid_busy", m_busy, 0);
    checkOutput("rst_mid_bit_idx", m_bidx, 0);
    checkOutput("rst_mid_pulses", {m_pe, m_fe, m_dv}, 3'b000);
    RX_IN = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    rst8 = 1'b0;
    idleCycles(6);
    @(negedge CLK);
    checkOutput("rst_mid_after", {m_busy, m_pe, m_fe, m_dv}, 4'b0000);
    @(posedge CLK); #1;

    // 7-bit DUT: parity error, then a good 7E1 frame
    rst8 = 1'b1; sel = 7;
    @(posedge CLK); #1 rst7 = 1'b0;
    idleCycles(1);
    sendFrame(9'h055, 7, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycles(2);
    sendFrame(9'h02B, 7, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycles(2);
    rst7 = 1'b1; sel = 8;
    @(posedge CLK); #1 rst8 = 1'b0;
    idleCycles(1);

    // all-zero frame with a low stop bit
    sendFrame(9'h000, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_BREAK_DET_EN
    RX_IN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checkOutput("break_busy", m_busy, 1);
      checkOutput("break_ferr", m_fe, (k == 0) ? 1 : 0);
      @(posedge CLK); #1;
    end
    RX_IN = 1'b1;
    @(negedge CLK);
    checkOutput("break_release_busy", m_busy, 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    checkOutput("break_exit", m_busy, 0);
    @(posedge CLK); #1;
`else
    RX_IN = 1'b1;
    @(negedge CLK);
    checkOutput("zero_ferr", {m_pe, m_fe, m_dv}, 3'b010);
    checkOutput("zero_idle", m_busy, 0);
    @(posedge CLK); #1;
`endif
    idleCycles(5);
    checkOutput("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm_p.md
UART_RX_FSM_P -- requirements
Module: uart_rx_fsm_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter BCNT_W, default 4, meaning width of the internal bit counter and of bit_idx; it SHALL hold DATA_W-1.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RST  in  1  reset, asynchronous and active-high.
REQ-005 RX_IN  in  1  serial line, idle high.
REQ-006 PAR_EN  in  1  1 = parity bit present.
REQ-007 STOP2  in  1  1 = two stop bits expected.
REQ-008 bit_done  in  1  one-cycle pulse from the edge counter at the end of each bit period.
REQ-009 strt_glitch, par_err, stp_err  in  1 each  checker results, valid in the cycle bit_done is high.
REQ-010 dat_sampl_en, enable  out  1  sampler and edge-counter enables.
REQ-011 str_chk_en, deser_en, par_chk_en, stp_chk_en  out  1  per-phase enables.
REQ-012 bit_idx  out  BCNT_W  index of the current data bit.
REQ-013 data_valid, frame_err, par_err_o  out  1  registered one-cycle pulses.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP, VALID, plus BREAK when configured; all enables SHALL be combinational decodes of the current state.
REQ-016 IDLE SHALL go to START on the first cycle RX_IN=0; no enables are asserted in IDLE.
REQ-017 START SHALL assert str_chk_en, dat_sampl_en and enable; on bit_done it SHALL go to IDLE if strt_glitch=1, else to DATA with bit_idx cleared to 0.
REQ-018 DATA SHALL assert deser_en, dat_sampl_en and enable; on bit_done it SHALL increment bit_idx.
REQ-019 In DATA, on bit_done with bit_idx=DATA_W-1, the FSM SHALL go to PARITY if PAR_EN=1, else to STOP.
REQ-020 PARITY SHALL assert par_chk_en; on bit_done with par_err=1 it SHALL go to IDLE and pulse par_err_o next cycle, else go to STOP.
REQ-021 STOP SHALL assert stp_chk_en; an internal stop counter SHALL count stop bits.
REQ-022 In STOP, on bit_done with stp_err=1, the FSM SHALL pulse frame_err and leave STOP.
REQ-023 In STOP, on bit_done of the last stop bit (1st if STOP2=0, 2nd if STOP2=1) with no error, it SHALL go to VALID.
REQ-024 VALID SHALL last one cycle, and data_valid SHALL be high exactly one cycle later.
REQ-025 VALID SHALL go to START if RX_IN=0 in that cycle (back-to-back frames), else to IDLE.
REQ-026 PAR_EN and STOP2 SHALL be sampled on the IDLE->START transition and held for the frame; mid-frame changes have no effect.
REQ-027 bit_done outside START/DATA/PARITY/STOP SHALL be ignored.
REQ-028 Illegal state encodings SHALL recover to IDLE on the next cycle with all outputs low.

Reset
REQ-029 RST=1 SHALL immediately force IDLE, bit_idx=0 and stop counter=0.
REQ-030 During reset, data_valid, frame_err, par_err_o and busy SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame, with no data_valid or error pulse after release.

Configuration
REQ-032 Macro UART_RX_BREAK_DET_EN defined: on a stop error with all data bits and the parity bit (if present) sampled 0, the FSM SHALL enter BREAK.
REQ-033 With the macro, entering BREAK SHALL pulse frame_err; the FSM SHALL remain in BREAK until RX_IN=1, then return to IDLE.
REQ-034 Macro undefined: BREAK SHALL not exist, and every stop error SHALL pulse frame_err and go to IDLE.

Verification
REQ-035 DATA_W=8, PAR_EN=0, STOP2=0, frame 0xA5 -> one data_valid pulse one cycle after VALID, no error pulses.
REQ-036 DATA_W=7, PAR_EN=1, par_err=1 at the parity bit -> par_err_o pulses once, no data_valid, return to IDLE.
REQ-037 STOP2=1, stp_err=1 on the 2nd stop bit -> frame_err pulses once, no data_valid.
REQ-038 RX_IN=0 for one sample and strt_glitch=1 -> back to IDLE after the first bit_done, busy drops.
REQ-039 Two back-to-back 0x3C frames, start bit in the VALID cycle -> two data_valid pulses, no IDLE cycle between frames.
REQ-040 RST pulsed at DATA bit_idx=4 -> IDLE immediately, no pulses; with UART_RX_BREAK_DET_EN, a 0x00 frame with stop=0 -> frame_err, BREAK held until RX_IN=1.
